// File: rtl/cmd_pkg.sv
// Shared constants and types for the command frame decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmd_pkg;

    // Frame delimiters
    localparam logic [7:0] SOF_BYTE = 8'h4B;
    localparam logic [7:0] EOF_BYTE = 8'h0D;

    // Command codes carried in the CMD byte
    localparam logic [7:0] CMD_INIT = 8'h00;
    localparam logic [7:0] CMD_EN   = 8'h02;
    localparam logic [7:0] CMD_INC  = 8'h0A;
    localparam logic [7:0] CMD_DEC  = 8'h12;

    // Abort causes reported on o_err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_EOF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_EOF
    } state_t;

    // LEN encodes (byte count - 1); the frame fits if LEN+1 bytes fit the payload.
    function automatic logic len_fits(input logic [7:0] len, input int nbytes);
        return (int'(len) + 1) <= nbytes;
    endfunction

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Byte-in / frame-out bundle of the command frame decoder.
// Latency: n/a (wiring only).
// Backpressure: none; the byte source has no ready, every i_rx_vld is consumed.
// master = byte source / result consumer, slave = decoder.
interface cmd_frame_decoder_if #(
    parameter int g_CH = 64
);
    logic [7:0]      i_rx_data;
    logic            i_rx_vld;
    logic [7:0]      o_cmd;
    logic [7:0]      o_len;
    logic [g_CH-1:0] o_payload;
    logic            o_frame_vld;
    logic            o_err;
    logic [1:0]      o_err_code;
    logic            o_busy;

    modport master (
        output i_rx_data, i_rx_vld,
        input  o_cmd, o_len, o_payload, o_frame_vld, o_err, o_err_code, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_vld,
        output o_cmd, o_len, o_payload, o_frame_vld, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/cmd_timeout.sv
// Inter-byte timeout counter: raises expired on the g_LIMIT-th cycle after the last kick.
// Latency: expired is combinational from the counter register (no extra stage).
// Backpressure: none. Ports: i_clk, i_rst, clear (hold at 0), kick (reload), expired.
module cmd_timeout #(
    parameter int g_LIMIT = 3000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic kick,
    output logic expired
);
    localparam int              c_W    = (g_LIMIT < 1) ? 1 : $clog2(g_LIMIT + 1);
    localparam logic [c_W-1:0]  c_LOAD = c_W'(g_LIMIT);
    localparam logic [c_W-1:0]  c_ONE  = c_W'(1);

    logic [c_W-1:0] cnt_q;

    // Kick wins over clear so the SOF byte arriving in IDLE arms the timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (kick) begin
            cnt_q <= c_LOAD;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - c_ONE;
        end
    end

    // Loaded with LIMIT at the kick edge, so a value of 1 marks the LIMIT-th edge.
    assign expired = (cnt_q == c_ONE);

endmodule

// File: rtl/cmd_frame_decoder.sv
// UART command frame parser: SOF CMD LEN payload(LEN+1) EOF -> registered cmd/len/payload.
// Latency: o_frame_vld / o_err one cycle after the byte (or timeout edge) that caused them.
// Backpressure: none; every byte is consumed. Ports: i_clk, i_rst, bus (slave side).
module cmd_frame_decoder
    import cmd_pkg::*;
#(
    parameter int g_CH         = 64,
    parameter int g_CLK_FREQ   = 30_000_000,
    parameter int g_TIMEOUT_US = 100
) (
    input  logic                i_clk,
    input  logic                i_rst,
    cmd_frame_decoder_if.slave  bus
);
    localparam int c_BYTES = g_CH / 8;
    localparam int c_T     = g_CLK_FREQ / 1_000_000 * g_TIMEOUT_US;

    state_t          state_q, state_d;
    logic [7:0]      cmd_sh, len_sh, pay_idx;
    logic [g_CH-1:0] pay_sh;

    logic            rx_vld;
    logic [7:0]      rx_data;
    logic            len_ok;
    logic            tmo_kick, tmo_clear, tmo_expired, tmo_hit;
    logic            commit, abort;
    logic [1:0]      abort_code;

    assign rx_vld  = bus.i_rx_vld;
    assign rx_data = bus.i_rx_data;
    assign len_ok  = len_fits(rx_data, c_BYTES);

    // The timer runs only while a frame is open; a byte arriving on the
    // expiry edge beats the timeout.
    assign tmo_kick  = rx_vld && ((state_q != ST_IDLE) || (rx_data == SOF_BYTE));
    assign tmo_clear = (state_q == ST_IDLE);
    assign tmo_hit   = tmo_expired && !rx_vld && (state_q != ST_IDLE);

    cmd_timeout #(
        .g_LIMIT (c_T)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (tmo_clear),
        .kick    (tmo_kick),
        .expired (tmo_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end else if (rx_vld) begin
            case (state_q)
                ST_IDLE:    if (rx_data == SOF_BYTE) state_d = ST_CMD;
                ST_CMD:     state_d = ST_LEN;
                ST_LEN:     state_d = len_ok ? ST_PAYLOAD : ST_IDLE;
                ST_PAYLOAD: if (pay_idx == len_sh) state_d = ST_EOF;
                ST_EOF:     state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        commit     = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        if (tmo_hit) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end else if (rx_vld) begin
            if (state_q == ST_LEN && !len_ok) begin
                abort      = 1'b1;
                abort_code = ERR_LEN;
            end else if (state_q == ST_EOF) begin
                if (rx_data == EOF_BYTE) begin
                    commit = 1'b1;
                end else begin
                    abort      = 1'b1;
                    abort_code = ERR_EOF;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_sh          <= '0;
            len_sh          <= '0;
            pay_sh          <= '0;
            pay_idx         <= '0;
            bus.o_cmd       <= '0;
            bus.o_len       <= '0;
            bus.o_payload   <= '0;
            bus.o_frame_vld <= 1'b0;
            bus.o_err       <= 1'b0;
            bus.o_err_code  <= ERR_NONE;
            bus.o_busy      <= 1'b0;
        end else begin
            bus.o_frame_vld <= commit;
            bus.o_err       <= abort;
            bus.o_busy      <= (state_d != ST_IDLE);
            if (abort) bus.o_err_code <= abort_code;

            if (commit) begin
                bus.o_cmd     <= cmd_sh;
                bus.o_len     <= len_sh;
                bus.o_payload <= pay_sh;
            end

            if (rx_vld && !tmo_hit) begin
                case (state_q)
                    ST_CMD: cmd_sh <= rx_data;
                    ST_LEN: begin
                        if (len_ok) begin
                            len_sh  <= rx_data;
                            pay_sh  <= '0;
                            pay_idx <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        for (int k = 0; k < c_BYTES; k++) begin
                            if (pay_idx == 8'(k)) pay_sh[8*k +: 8] <= rx_data;
                        end
                        pay_idx <= pay_idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
module tb_cmd_frame_decoder;
    import cmd_pkg::*;

    localparam int T = 20;  // 1 MHz * 20 us

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    cmd_frame_decoder_if #(.g_CH(64)) bw ();
    cmd_frame_decoder_if #(.g_CH(16)) bn ();

    cmd_frame_decoder #(.g_CH(64), .g_CLK_FREQ(1_000_000), .g_TIMEOUT_US(T)) dut_w (
        .i_clk (i_clk), .i_rst (i_rst), .bus (bw)
    );
    cmd_frame_decoder #(.g_CH(16), .g_CLK_FREQ(1_000_000), .g_TIMEOUT_US(T)) dut_n (
        .i_clk (i_clk), .i_rst (i_rst), .bus (bn)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model data: byte stream and expected event per byte index
    logic [7:0]  stream[$];
    int          ek[$];      // 0 none, 1 frame, 2 error
    logic [1:0]  ecode[$];
    logic [7:0]  ecmd[$];
    logic [7:0]  elen[$];
    logic [63:0] epay[$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input bit nar, input logic [7:0] b);
        if (nar) begin bn.i_rx_data = b; bn.i_rx_vld = 1'b1; end
        else     begin bw.i_rx_data = b; bw.i_rx_vld = 1'b1; end
        tick();
        bn.i_rx_vld = 1'b0;
        bw.i_rx_vld = 1'b0;
    endtask

    // Frame-level parse of a complete byte stream into expected events.
    task automatic model_stream();
        int i, n, e;
        logic [7:0]  c, l;
        logic [63:0] p;
        n = stream.size();
        ek.delete(); ecode.delete(); ecmd.delete(); elen.delete(); epay.delete();
        for (int j = 0; j < n; j++) begin
            ek.push_back(0); ecode.push_back(2'd0); ecmd.push_back(8'd0);
            elen.push_back(8'd0); epay.push_back(64'd0);
        end
        i = 0;
        while (i < n) begin
            if (stream[i] != 8'h4B) begin i++; continue; end
            if (i + 2 >= n) break;
            c = stream[i+1];
            l = stream[i+2];
            if (int'(l) + 1 > 8) begin
                ek[i+2] = 2; ecode[i+2] = 2'd1; i = i + 3; continue;
            end
            e = i + 3 + int'(l) + 1;
            if (e >= n) break;
            p = '0;
            for (int k = 0; k <= int'(l); k++) p[8*k +: 8] = stream[i+3+k];
            if (stream[e] == 8'h0D) begin
                ek[e] = 1; ecmd[e] = c; elen[e] = l; epay[e] = p;
            end else begin
                ek[e] = 2; ecode[e] = 2'd2;
            end
            i = e + 1;
        end
    endtask

    task automatic gen_stream();
        int r, l;
        logic [7:0] b;
        stream.delete();
        repeat (10) begin
            r = $urandom_range(0, 9);
            if (r <= 5 || r == 8) begin
                l = $urandom_range(0, 7);
                stream.push_back(8'h4B);
                stream.push_back(8'($urandom_range(0, 255)));
                stream.push_back(8'(l));
                for (int k = 0; k <= l; k++) stream.push_back(8'($urandom_range(0, 255)));
                if (r == 8) begin
                    do b = 8'($urandom_range(0, 255)); while (b == 8'h0D);
                    stream.push_back(b);
                end else begin
                    stream.push_back(8'h0D);
                end
            end else if (r <= 7) begin
                stream.push_back(8'h4B);
                stream.push_back(8'($urandom_range(0, 255)));
                stream.push_back(8'($urandom_range(8, 255)));
            end else begin
                do b = 8'($urandom_range(0, 255)); while (b == 8'h4B);
                stream.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (bw.o_payload !== 64'd0 || bw.o_cmd !== 8'd0 || bw.o_len !== 8'd0)
            begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", bw.o_cmd, bw.o_len, bw.o_payload); end
        n_tests++; if ({bw.o_frame_vld, bw.o_err, bw.o_err_code, bw.o_busy} !== 5'd0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bw.o_frame_vld, bw.o_err, bw.o_err_code, bw.o_busy}); end
        n_tests++; if ({bn.o_payload, bn.o_err, bn.o_err_code, bn.o_busy} !== 20'd0)
            begin n_fail++; $display("FAIL reset_narrow: got %h want 0", {bn.o_payload, bn.o_err, bn.o_err_code, bn.o_busy}); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_frames();
        logic [7:0] f1[12] = '{8'h4B, 8'h02, 8'h07, 8'hF1, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
        logic [7:0] f2[5]  = '{8'h4B, 8'h00, 8'h00, 8'h45, 8'h0D};
        int strobes = 0;
        for (int i = 0; i < 12; i++) begin
            send(0, f1[i]);
            if (i == 0) begin
                n_tests++; if (bw.o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_sof: got %b want 1", bw.o_busy); end
            end
            if (i < 11 && (bw.o_frame_vld || bw.o_err)) strobes++;
        end
        n_tests++; if (bw.o_frame_vld !== 1'b1 || bw.o_err !== 1'b0)
            begin n_fail++; $display("FAIL f036_vld: got vld=%b err=%b want 1/0", bw.o_frame_vld, bw.o_err); end
        n_tests++; if (bw.o_cmd !== 8'h02 || bw.o_len !== 8'h07 || bw.o_payload !== 64'h00000000050000F1)
            begin n_fail++; $display("FAIL f036_data: got %h %h %h want 02 07 00000000050000f1", bw.o_cmd, bw.o_len, bw.o_payload); end
        n_tests++; if (strobes !== 0) begin n_fail++; $display("FAIL f036_early: got %0d strobes want 0", strobes); end
        tick();
        n_tests++; if (bw.o_frame_vld !== 1'b0 || bw.o_busy !== 1'b0)
            begin n_fail++; $display("FAIL f036_after: got vld=%b busy=%b want 0/0", bw.o_frame_vld, bw.o_busy); end
        for (int i = 0; i < 5; i++) send(0, f2[i]);
        n_tests++; if (bw.o_frame_vld !== 1'b1 || bw.o_cmd !== 8'h00 || bw.o_len !== 8'h00 || bw.o_payload !== 64'h45)
            begin n_fail++; $display("FAIL f037: got %b %h %h %h want 1 00 00 45", bw.o_frame_vld, bw.o_cmd, bw.o_len, bw.o_payload); end
    endtask

    task automatic test_bad_len();
        int strobes = 0;
        send(0, 8'h4B); send(0, 8'h0A); send(0, 8'h08);
        n_tests++; if (bw.o_err !== 1'b1 || bw.o_err_code !== ERR_LEN || bw.o_busy !== 1'b0)
            begin n_fail++; $display("FAIL badlen: got err=%b code=%0d busy=%b want 1/1/0", bw.o_err, bw.o_err_code, bw.o_busy); end
        for (int i = 1; i <= 9; i++) begin
            send(0, 8'(i));
            if (bw.o_frame_vld || bw.o_err || bw.o_busy) strobes++;
        end
        send(0, 8'h0D);
        if (bw.o_frame_vld || bw.o_err || bw.o_busy) strobes++;
        n_tests++; if (strobes !== 0) begin n_fail++; $display("FAIL badlen_ignore: got %0d events want 0", strobes); end
        n_tests++; if (bw.o_err_code !== ERR_LEN || bw.o_payload !== 64'h45)
            begin n_fail++; $display("FAIL badlen_hold: got code=%0d pay=%h want 1 45", bw.o_err_code, bw.o_payload); end
    endtask

    task automatic test_bad_eof();
        send(0, 8'h4B); send(0, 8'h12); send(0, 8'h00); send(0, 8'hAA); send(0, 8'h0E);
        n_tests++; if (bw.o_err !== 1'b1 || bw.o_err_code !== ERR_EOF || bw.o_frame_vld !== 1'b0)
            begin n_fail++; $display("FAIL badeof: got err=%b code=%0d vld=%b want 1/2/0", bw.o_err, bw.o_err_code, bw.o_frame_vld); end
        n_tests++; if (bw.o_payload !== 64'h45 || bw.o_cmd !== 8'h00)
            begin n_fail++; $display("FAIL badeof_hold: got %h %h want 00 45", bw.o_cmd, bw.o_payload); end
    endtask

    task automatic test_timeout();
        int k = 0;
        send(0, 8'h4B); send(0, 8'h0A);
        while (bw.o_err !== 1'b1 && k < 3*T) begin tick(); k++; end
        n_tests++; if (k !== T) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", k, T); end
        n_tests++; if (bw.o_err_code !== ERR_TIMEOUT || bw.o_busy !== 1'b0)
            begin n_fail++; $display("FAIL timeout_code: got code=%0d busy=%b want 3/0", bw.o_err_code, bw.o_busy); end
        tick();
        n_tests++; if (bw.o_err !== 1'b0 || bw.o_err_code !== ERR_TIMEOUT)
            begin n_fail++; $display("FAIL timeout_hold: got err=%b code=%0d want 0/3", bw.o_err, bw.o_err_code); end
    endtask

    task automatic test_timeout_race();
        int errs = 0;
        send(0, 8'h4B); send(0, 8'h0A);
        repeat (T-1) begin tick(); if (bw.o_err) errs++; end
        send(0, 8'h00);
        if (bw.o_err) errs++;
        n_tests++; if (errs !== 0 || bw.o_busy !== 1'b1)
            begin n_fail++; $display("FAIL race_len: got errs=%0d busy=%b want 0/1", errs, bw.o_busy); end
        repeat (T-1) begin tick(); if (bw.o_err) errs++; end
        send(0, 8'h5A);
        if (bw.o_err) errs++;
        send(0, 8'h0D);
        n_tests++; if (errs !== 0 || bw.o_frame_vld !== 1'b1 || bw.o_cmd !== 8'h0A || bw.o_payload !== 64'h5A)
            begin n_fail++; $display("FAIL race_frame: got errs=%0d vld=%b cmd=%h pay=%h want 0 1 0a 5a", errs, bw.o_frame_vld, bw.o_cmd, bw.o_payload); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[6] = '{8'h4B, 8'h07, 8'h01, 8'hCD, 8'hAB, 8'h0D};
        int frames = 0, errs = 0;
        send(0, 8'h4B); send(0, 8'h02); send(0, 8'h03); send(0, 8'h11); send(0, 8'h22);
        i_rst = 1'b1;
        repeat (2) begin tick(); if (bw.o_err) errs++; end
        i_rst = 1'b0;
        n_tests++; if (bw.o_busy !== 1'b0 || bw.o_payload !== 64'd0 || bw.o_err_code !== 2'd0)
            begin n_fail++; $display("FAIL rstmid_clear: got busy=%b pay=%h code=%0d want 0", bw.o_busy, bw.o_payload, bw.o_err_code); end
        for (int i = 0; i < 6; i++) begin
            send(0, f[i]);
            if (bw.o_frame_vld) frames++;
            if (bw.o_err) errs++;
        end
        tick();
        if (bw.o_frame_vld) frames++;
        if (bw.o_err) errs++;
        n_tests++; if (frames !== 1 || errs !== 0)
            begin n_fail++; $display("FAIL rstmid_count: got frames=%0d errs=%0d want 1/0", frames, errs); end
        n_tests++; if (bw.o_cmd !== 8'h07 || bw.o_len !== 8'h01 || bw.o_payload !== 64'hABCD)
            begin n_fail++; $display("FAIL rstmid_data: got %h %h %h want 07 01 abcd", bw.o_cmd, bw.o_len, bw.o_payload); end
    endtask

    task automatic test_narrow();
        logic [7:0] f1[12] = '{8'h4B, 8'h02, 8'h07, 8'hF1, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
        logic [7:0] f2[6]  = '{8'h4B, 8'h05, 8'h01, 8'h34, 8'h12, 8'h0D};
        int frames = 0, errs = 0;
        for (int i = 0; i < 12; i++) begin
            send(1, f1[i]);
            if (i == 2) begin
                n_tests++; if (bn.o_err !== 1'b1 || bn.o_err_code !== ERR_LEN)
                    begin n_fail++; $display("FAIL narrow_len: got err=%b code=%0d want 1/1", bn.o_err, bn.o_err_code); end
            end
            if (bn.o_frame_vld) frames++;
            if (bn.o_err) errs++;
        end
        n_tests++; if (frames !== 0 || errs !== 1)
            begin n_fail++; $display("FAIL narrow_count: got frames=%0d errs=%0d want 0/1", frames, errs); end
        for (int i = 0; i < 6; i++) send(1, f2[i]);
        n_tests++; if (bn.o_frame_vld !== 1'b1 || bn.o_cmd !== 8'h05 || bn.o_len !== 8'h01 || bn.o_payload !== 16'h1234)
            begin n_fail++; $display("FAIL narrow_max: got %b %h %h %h want 1 05 01 1234", bn.o_frame_vld, bn.o_cmd, bn.o_len, bn.o_payload); end
    endtask

    task automatic test_random();
        int g;
        repeat (4) begin
            gen_stream();
            model_stream();
            for (int j = 0; j < stream.size(); j++) begin
                send(0, stream[j]);
                n_tests++; if (bw.o_frame_vld !== (ek[j] == 1) || bw.o_err !== (ek[j] == 2))
                    begin n_fail++; $display("FAIL rnd_strobe[%0d]: got vld=%b err=%b want kind %0d", j, bw.o_frame_vld, bw.o_err, ek[j]); end
                if (ek[j] == 1) begin
                    n_tests++; if (bw.o_cmd !== ecmd[j] || bw.o_len !== elen[j] || bw.o_payload !== epay[j])
                        begin n_fail++; $display("FAIL rnd_data[%0d]: got %h %h %h want %h %h %h", j, bw.o_cmd, bw.o_len, bw.o_payload, ecmd[j], elen[j], epay[j]); end
                end else if (ek[j] == 2) begin
                    n_tests++; if (bw.o_err_code !== ecode[j])
                        begin n_fail++; $display("FAIL rnd_code[%0d]: got %0d want %0d", j, bw.o_err_code, ecode[j]); end
                end
                g = $urandom_range(0, 3);
                repeat (g) begin
                    tick();
                    n_tests++; if (bw.o_frame_vld !== 1'b0 || bw.o_err !== 1'b0)
                        begin n_fail++; $display("FAIL rnd_gap[%0d]: got vld=%b err=%b want 0/0", j, bw.o_frame_vld, bw.o_err); end
                end
            end
            n_tests++; if (bw.o_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle: got busy=%b want 0", bw.o_busy); end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bw.i_rx_vld = 1'b0; bw.i_rx_data = 8'h00;
        bn.i_rx_vld = 1'b0; bn.i_rx_data = 8'h00;
        test_reset();
        test_frames();
        test_bad_len();
        test_bad_eof();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_narrow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
